// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- element tables, element index type and controller states
package mbist_pkg;

    typedef logic [2:0] elem_t;

    localparam int NUM_ELEM = 6;

    // One bit per element, bit n = element En (bits 6..7 unused)
    localparam logic [7:0] ELEM_DOWN      = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
    localparam logic [7:0] ELEM_READ_BIT  = 8'b0001_0100;
    localparam logic [7:0] ELEM_WRITE_BIT = 8'b0000_1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic logic op_is_write(elem_t e, logic phase);
        return ELEM_HAS_WRITE[e] && (!ELEM_HAS_READ[e] || phase);
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// rtl/mbist_cmp.sv - 2-stage read compare pipeline with first-fail capture
// Optional MBIST_ERR_COUNT_EN adds a saturating mismatch counter.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_expect,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  elem_t                 rd_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
`ifdef MBIST_ERR_COUNT_EN
    output logic [ADDR_WIDTH+2:0] err_count,
`endif
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output elem_t                 fail_elem
);

    logic                  s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
    logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
    elem_t                 s1_elem, s2_elem;
    logic                  mismatch;

    // Stage 2 lines up with the memory's second read-data register
    assign mismatch = s2_valid && (rdata != s2_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_exp    <= '0;
            s2_exp    <= '0;
            s1_addr   <= '0;
            s2_addr   <= '0;
            s1_elem   <= '0;
            s2_elem   <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
`ifdef MBIST_ERR_COUNT_EN
            err_count <= '0;
`endif
        end else begin
            s1_valid <= rd_valid;
            s1_exp   <= rd_expect;
            s1_addr  <= rd_addr;
            s1_elem  <= rd_elem;
            s2_valid <= s1_valid;
            s2_exp   <= s1_exp;
            s2_addr  <= s1_addr;
            s2_elem  <= s1_elem;
            if (clear) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
`ifdef MBIST_ERR_COUNT_EN
                err_count <= '0;
`endif
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= s2_addr;
                    fail_elem <= s2_elem;
                end
`ifdef MBIST_ERR_COUNT_EN
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/march_mbist_ctrl.sv
// rtl/march_mbist_ctrl.sv - March C- BIST sequencer for one single-port memory
// Optional MBIST_ERR_COUNT_EN exposes the mismatch counter as err_count.
module march_mbist_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
`ifdef MBIST_ERR_COUNT_EN
    output logic [ADDR_WIDTH+2:0] err_count,
`endif
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    elem_t                 elem;
    logic                  phase;
    logic                  drain_cnt;
    elem_t                 nxt_elem;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic                  nxt_phase;
    logic                  nxt_write;
    logic                  run_end;
    logic                  rd_valid;
    logic                  clear;

    // Next op: r/w elements take a second cycle at the same address
    always_comb begin
        nxt_elem  = elem;
        nxt_addr  = mem_address;
        nxt_phase = 1'b0;
        run_end   = 1'b0;
        if (ELEM_HAS_READ[elem] && ELEM_HAS_WRITE[elem] && !phase) begin
            nxt_phase = 1'b1;
        end else if (ELEM_DOWN[elem] ? (mem_address == '0) : (mem_address == LAST_ADDR)) begin
            if (elem == elem_t'(NUM_ELEM - 1)) begin
                run_end = 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
                nxt_addr = ELEM_DOWN[nxt_elem] ? LAST_ADDR : '0;
            end
        end else if (ELEM_DOWN[elem]) begin
            nxt_addr = mem_address - ADDR_WIDTH'(1);
        end else begin
            nxt_addr = mem_address + ADDR_WIDTH'(1);
        end
        nxt_write = op_is_write(nxt_elem, nxt_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            elem           <= '0;
            phase          <= 1'b0;
            drain_cnt      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_write_read <= 1'b0;
                    if (start) begin
                        state       <= ST_PREP;
                        busy        <= 1'b1;
                        mem_address <= '0;
                        mem_wdata   <= '0;
                    end
                end
                ST_PREP: begin
                    state          <= ST_RUN;
                    elem           <= '0;
                    phase          <= 1'b0;
                    mem_address    <= '0;
                    mem_write_read <= op_is_write(elem_t'(0), 1'b0);
                    mem_wdata      <= {DATA_WIDTH{ELEM_WRITE_BIT[0]}};
                end
                ST_RUN: begin
                    if (run_end) begin
                        state          <= ST_DRAIN;
                        drain_cnt      <= 1'b0;
                        mem_write_read <= 1'b0;
                        mem_wdata      <= '0;
                    end else begin
                        elem           <= nxt_elem;
                        phase          <= nxt_phase;
                        mem_address    <= nxt_addr;
                        mem_write_read <= nxt_write;
                        // Loaded during the read so the memory's wdata register is ready at the write
                        mem_wdata      <= {DATA_WIDTH{ELEM_WRITE_BIT[nxt_elem]}};
                    end
                end
                ST_DRAIN: begin
                    mem_write_read <= 1'b0;
                    if (drain_cnt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid = (state == ST_RUN) && !mem_write_read;
    assign clear    = (state == ST_IDLE) && start;

    mbist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .rd_valid  (rd_valid),
        .rd_expect ({DATA_WIDTH{ELEM_READ_BIT[elem]}}),
        .rd_addr   (mem_address),
        .rd_elem   (elem),
        .rdata     (mem_rdata),
`ifdef MBIST_ERR_COUNT_EN
        .err_count (err_count),
`endif
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_march_mbist_ctrl.sv
// tb/tb_march_mbist_ctrl.sv - scoreboard bench for march_mbist_ctrl with faulty memory model
`timescale 1ns/1ps
module tb_march_mbist_ctrl;

    localparam int DW          = 8;
    localparam int AW          = 4;
    localparam int DEPTH       = 16;
    localparam int BUSY_CYCLES = 1 + 10 * DEPTH + 2;

    localparam int F_NONE = 0;
    localparam int F_SA0  = 1;
    localparam int F_SA1  = 2;
    localparam int F_CPL  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rdata;
`ifdef MBIST_ERR_COUNT_EN
    logic [AW+2:0] err_count;
`endif

    always #5 clk = ~clk;

    march_mbist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .fail_addr      (fail_addr),
        .fail_elem      (fail_elem),
`ifdef MBIST_ERR_COUNT_EN
        .err_count      (err_count),
`endif
        .mem_write_read (mem_write_read),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (rdata)
    );

    int errors = 0;
    int checks = 0;

    int f_kind = F_NONE;
    int f_addr = 0;
    int f_vict = 0;
    int f_bit  = 0;

    // March C- as listed: direction, read, write, read value, write value
    int el_down[6] = '{0, 0, 0, 1, 1, 0};
    int el_rd[6]   = '{0, 1, 1, 1, 1, 1};
    int el_wr[6]   = '{1, 1, 1, 1, 1, 0};
    int el_rv[6]   = '{0, 0, 1, 0, 1, 0};
    int el_wv[6]   = '{0, 1, 0, 1, 0, 0};

    typedef struct {
        bit            we;
        bit            chk_addr;
        int            addr;
        logic [DW-1:0] wv;
    } op_t;

    typedef struct {
        bit fail;
        int addr;
        int elem;
        int errs;
    } res_t;

    op_t  ops[$];
    res_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] read_fault(logic [DW-1:0] v, int a);
        logic [DW-1:0] m;
        m = DW'(1) << f_bit;
        if (f_kind == F_SA0 && a == f_addr) return v & ~m;
        if (f_kind == F_SA1 && a == f_addr) return v | m;
        return v;
    endfunction

    // Memory under test: registered wdata, 2-cycle read latency, injected faults
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wdata_q = '0;
    logic [DW-1:0] rd_pipe = '0;
    always @(posedge clk) begin
        wdata_q <= mem_wdata;
        rd_pipe <= read_fault(mem[mem_address], int'(mem_address));
        rdata   <= rd_pipe;
        if (mem_write_read) begin
            mem[mem_address] <= wdata_q;
            if (f_kind == F_CPL && int'(mem_address) == f_addr && wdata_q == {DW{1'b1}})
                mem[f_vict] <= mem[f_vict] | (DW'(1) << f_bit);
        end
    end

    function automatic op_t mk_op(bit we, bit ca, int a, logic [DW-1:0] wv);
        op_t o;
        o.we = we; o.chk_addr = ca; o.addr = a; o.wv = wv;
        return o;
    endfunction

    // Walks March C- over an array model, queueing expected ops and the expected outcome
    task automatic build_and_model(output res_t r);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] v, rv, wv;
        int a;
        r.fail = 0; r.addr = 0; r.elem = 0; r.errs = 0;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        ops.push_back(mk_op(1'b0, 1'b1, 0, '0));
        for (int e = 0; e < 6; e++) begin
            rv = (el_rv[e] != 0) ? '1 : '0;
            wv = (el_wv[e] != 0) ? '1 : '0;
            for (int i = 0; i < DEPTH; i++) begin
                a = (el_down[e] != 0) ? DEPTH - 1 - i : i;
                if (el_rd[e] != 0) begin
                    ops.push_back(mk_op(1'b0, 1'b1, a, '0));
                    v = read_fault(m[a], a);
                    if (v != rv) begin
                        if (!r.fail) begin
                            r.fail = 1; r.addr = a; r.elem = e;
                        end
                        r.errs++;
                    end
                end
                if (el_wr[e] != 0) begin
                    ops.push_back(mk_op(1'b1, 1'b1, a, wv));
                    m[a] = wv;
                    if (f_kind == F_CPL && a == f_addr && wv == {DW{1'b1}})
                        m[f_vict] = m[f_vict] | (DW'(1) << f_bit);
                end
            end
        end
        ops.push_back(mk_op(1'b0, 1'b0, 0, '0));
        ops.push_back(mk_op(1'b0, 1'b0, 0, '0));
    endtask

    // Monitor: checks every busy cycle against the op queue and each done against the result queue
    int            busy_cnt = 0;
    bit            mon_skip = 0;
    logic [DW-1:0] prev_wdata = '0;
    logic          prev_done = 1'b0;
    always @(negedge clk) begin
        op_t  o;
        res_t r;
        if (mon_skip || rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (ops.size() == 0) begin
                    chk("op_queue_underflow", 1, 0);
                end else begin
                    o = ops.pop_front();
                    chk("op_write_read", longint'(mem_write_read), longint'(o.we));
                    if (o.chk_addr) chk("op_address", longint'(mem_address), longint'(o.addr));
                    if (o.we) chk("wdata_prev_cycle", longint'(prev_wdata), longint'(o.wv));
                end
            end
            if (done) begin
                chk("done_single_pulse", longint'(prev_done), 0);
                chk("busy_low_at_done", longint'(busy), 0);
                chk("busy_cycles", busy_cnt, BUSY_CYCLES);
                chk("ops_consumed", ops.size(), 0);
                if (exp_q.size() == 0) begin
                    chk("result_queue_underflow", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("fail", longint'(fail), longint'(r.fail));
                    chk("fail_addr", longint'(fail_addr), r.addr);
                    chk("fail_elem", longint'(fail_elem), r.elem);
`ifdef MBIST_ERR_COUNT_EN
                    chk("err_count", longint'(err_count), r.errs);
`endif
                end
                busy_cnt = 0;
            end
        end
        prev_wdata = mem_wdata;
        prev_done  = done;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_fail"}, longint'(fail), 0);
        chk({tag, "_fail_addr"}, longint'(fail_addr), 0);
        chk({tag, "_fail_elem"}, longint'(fail_elem), 0);
        chk({tag, "_write_read"}, longint'(mem_write_read), 0);
        chk({tag, "_address"}, longint'(mem_address), 0);
        chk({tag, "_wdata"}, longint'(mem_wdata), 0);
`ifdef MBIST_ERR_COUNT_EN
        chk({tag, "_err_count"}, longint'(err_count), 0);
`endif
    endtask

    task automatic run_one(input int kind, input int fa, input int fv, input int fb,
                           input bit use_model, input res_t cres, input bit poke);
        res_t mr;
        int   n;
        bit   seen;
        f_kind = kind; f_addr = fa; f_vict = fv; f_bit = fb;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        build_and_model(mr);
        exp_q.push_back(use_model ? mr : cres);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            start = (poke && (n == 50 || n == 120)) ? 1'b1 : 1'b0;
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    function automatic res_t mk_res(bit f, int a, int e, int c);
        res_t r;
        r.fail = f; r.addr = a; r.elem = e; r.errs = c;
        return r;
    endfunction

    initial begin
        res_t mr;
        int   kind, fa, fv, fb;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_one(F_NONE, 0, 0, 0, 0, mk_res(0, 0, 0, 0), 0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("final_mem_%0d", i), longint'(mem[i]), 0);

        run_one(F_SA0, 5, 0, 3, 0, mk_res(1, 5, 2, 2), 0);
        run_one(F_SA1, 0, 0, 0, 0, mk_res(1, 0, 1, 3), 0);
        run_one(F_CPL, 9, 10, 5, 0, mk_res(1, 10, 1, 1), 0);
        run_one(F_CPL, 10, 9, 5, 0, mk_res(1, 9, 3, 1), 0);
        run_one(F_NONE, 0, 0, 0, 0, mk_res(0, 0, 0, 0), 1);

        for (int k = 0; k < 6; k++) begin
            kind = 1 + int'($urandom_range(0, 2));
            fa   = int'($urandom_range(0, DEPTH - 1));
            fv   = (fa + 1 + int'($urandom_range(0, DEPTH - 2))) % DEPTH;
            fb   = int'($urandom_range(0, DW - 1));
            run_one(kind, fa, fv, fb, 1, mk_res(0, 0, 0, 0), 0);
        end

        // Mid-test reset, with a fault present so the diagnostics are non-zero
        f_kind = F_SA1; f_addr = 0; f_vict = 0; f_bit = 0;
        build_and_model(mr);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (40) @(negedge clk);
        mon_skip = 1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        ops.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_write", longint'(mem_write_read), 0);
            chk("idle_not_busy", longint'(busy), 0);
        end
        mon_skip = 0;
        run_one(F_NONE, 0, 0, 0, 0, mk_res(0, 0, 0, 0), 0);

        chk("results_consumed", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
